instr_mem_responder: RTL and testbench

Instruction-memory responder serving the core's fetch port (ins_address out, instruction_i/instruction_valid in). It holds a word-addressed instruction store and returns the addressed word after a configurable number of wait states. A sideband program-load port fills the store at boot or from the bench. It sits at the top level beside rv32i_core, driving the core's instruction inputs.

---
 rtl/instr_mem_responder_pkg.sv | 22 ++
 rtl/imem_sram_1r1w.sv | 27 ++
 rtl/instr_mem_responder.sv | 146 ++++++++++++++
 tb/tb_instr_mem_responder.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/instr_mem_responder_pkg.sv
// Shared definitions for the instruction-memory responder: default NOP word and fetch FSM states.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package instr_mem_responder_pkg;

    // addi x0,x0,0 -- substituted on fetch errors and presented out of reset
    localparam logic [31:0] NOP_DEFAULT = 32'h0000_0013;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        READY = 2'd2
    } fetch_state_e;

    // $clog2 clamped to at least 1 so degenerate parameters still give a real vector
    function automatic int clog2_min1(input int value);
        int r;
        r = $clog2(value);
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/imem_sram_1r1w.sv
// Instruction store: one synchronous read port, one synchronous write port.
// Latency: read data appears the cycle after rd_addr is presented; read-during-write returns old data.
// Backpressure: none, both ports accept every cycle.
module imem_sram_1r1w #(
    parameter int DEPTH = 1024,
    parameter int WIDTH = 32,
    parameter int AW    = 10
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Storage write plus registered read; contents are deliberately not reset
    always_ff @(posedge clk) begin
        if (we) begin
            mem[wr_addr] <= wr_data;
        end
        rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/instr_mem_responder.sv
// Fetch-port responder: returns the word at ins_address from a word-addressed store, NOP on error.
// Latency: WAIT_STATES+2 cycles from a new address (accept cycle, wait states, read cycle).
// Backpressure: none; a changed address or a program write to the served word restarts the access.
module instr_mem_responder
    import instr_mem_responder_pkg::*;
#(
    parameter int              size        = 32,
    parameter int              DEPTH_WORDS = 1024,
    parameter int              WAIT_STATES = 1,
    parameter logic [size-1:0] NOP_WORD    = size'(NOP_DEFAULT)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [size-1:0] ins_address,
    output logic [size-1:0] instruction_i,
    output logic            instruction_valid,
    output logic            fetch_error_o,
    input  logic            prog_we,
    input  logic [size-1:0] prog_addr,
    input  logic [size-1:0] prog_data
);

    localparam int              AW        = clog2_min1(DEPTH_WORDS);
    localparam int              CW        = clog2_min1(WAIT_STATES + 1);
    localparam logic [size-1:0] DEPTH_LIM = size'(DEPTH_WORDS);
    localparam logic [CW-1:0]   CNT_LOAD  = CW'(WAIT_STATES);

    fetch_state_e    state_q, state_d;
    logic [size-1:0] addr_q, addr_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [size-1:0] data_q, data_d;
    logic            err_q, err_d;
    logic            valid_q, valid_d;
    logic            fwd_vld_q, fwd_vld_d;
    logic [size-1:0] fwd_dat_q, fwd_dat_d;

    logic            prog_in_range;
    logic            hit_write;
    logic            restart;
    logic            addr_err;
    logic [AW-1:0]   rd_idx;
    logic [AW-1:0]   wr_idx;
    logic [size-1:0] rd_word;
    logic            prog_addr_unused;

    // Byte-offset bits of the load address carry no information
    assign prog_addr_unused = ^prog_addr[1:0];

    assign prog_in_range = (prog_addr >> 2) < DEPTH_LIM;
    assign hit_write     = prog_we && prog_in_range
                        && (prog_addr[size-1:2] == addr_q[size-1:2]);
    assign restart       = (state_q == IDLE) || (ins_address != addr_q) || hit_write;
    assign addr_err      = (addr_q[1:0] != 2'b00) || ((addr_q >> 2) >= DEPTH_LIM);

    // Read index follows the next address so a zero-wait access reads during its accept edge
    assign rd_idx = addr_d[AW+1:2];
    assign wr_idx = prog_addr[AW+1:2];

    imem_sram_1r1w #(
        .DEPTH (DEPTH_WORDS),
        .WIDTH (size),
        .AW    (AW)
    ) u_sram (
        .clk     (clk),
        .we      (prog_we && prog_in_range),
        .wr_addr (wr_idx),
        .wr_data (prog_data),
        .rd_addr (rd_idx),
        .rd_data (rd_word)
    );

    // Next-state logic: restart on new address or hit write, count wait states, then latch the word
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        cnt_d     = cnt_q;
        data_d    = data_q;
        err_d     = err_q;
        valid_d   = valid_q;
        // A write landing on the word being read this edge would be missed by the
        // old-data read; remember it so the completing read can use the new value.
        fwd_vld_d = prog_we && prog_in_range && (wr_idx == rd_idx);
        fwd_dat_d = prog_data;

        if (restart) begin
            addr_d  = ins_address;
            valid_d = 1'b0;
            cnt_d   = CNT_LOAD;
            state_d = WAIT;
        end else begin
            case (state_q)
                WAIT: begin
                    if (cnt_q != '0) begin
                        cnt_d = cnt_q - CW'(1);
                    end else begin
                        if (addr_err) begin
                            data_d = NOP_WORD;
                        end else if (fwd_vld_q) begin
                            data_d = fwd_dat_q;
                        end else begin
                            data_d = rd_word;
                        end
                        err_d   = addr_err;
                        valid_d = 1'b1;
                        state_d = READY;
                    end
                end
                READY: begin
                    state_d = READY;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // Fetch FSM and response registers; reset aborts any access in flight
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            cnt_q     <= '0;
            data_q    <= NOP_WORD;
            err_q     <= 1'b0;
            valid_q   <= 1'b0;
            fwd_vld_q <= 1'b0;
            fwd_dat_q <= '0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            cnt_q     <= cnt_d;
            data_q    <= data_d;
            err_q     <= err_d;
            valid_q   <= valid_d;
            fwd_vld_q <= fwd_vld_d;
            fwd_dat_q <= fwd_dat_d;
        end
    end

    // Qualify with the live address so a redirect never sees stale data as valid
    assign instruction_i     = data_q;
    assign instruction_valid = valid_q && (ins_address == addr_q);
    assign fetch_error_o     = err_q && instruction_valid;

endmodule

// File: tb/tb_instr_mem_responder.sv
// Directed bench for instr_mem_responder with WAIT_STATES=1 (three-edge fetch latency).
// Latency: n/a.
// Backpressure: n/a.
module tb_instr_mem_responder;

    localparam int          DEPTH = 1024;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    logic        clk;
    logic        reset;
    logic [31:0] ins_address;
    logic [31:0] instruction_i;
    logic        instruction_valid;
    logic        fetch_error_o;
    logic        prog_we;
    logic [31:0] prog_addr;
    logic [31:0] prog_data;

    int n_chk;
    int n_err;

    instr_mem_responder #(
        .size        (32),
        .DEPTH_WORDS (DEPTH),
        .WAIT_STATES (1),
        .NOP_WORD    (NOP)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .ins_address       (ins_address),
        .instruction_i     (instruction_i),
        .instruction_valid (instruction_valid),
        .fetch_error_o     (fetch_error_o),
        .prog_we           (prog_we),
        .prog_addr         (prog_addr),
        .prog_data         (prog_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic prog_wr(input logic [31:0] a, input logic [31:0] d);
        prog_addr = a;
        prog_data = d;
        prog_we   = 1'b1;
        tick();
        prog_we   = 1'b0;
    endtask

    // Present an address and expect valid exactly on the third edge after it appears
    task automatic fetch(input string tag, input logic [31:0] a,
                         input logic [31:0] exp_dat, input logic exp_err);
        ins_address = a;
        #1;
        chk({tag, "_drop"}, 32'(instruction_valid), 32'd0);
        for (int i = 1; i < 3; i++) begin
            tick();
            chk({tag, "_early"}, 32'(instruction_valid), 32'd0);
        end
        tick();
        chk({tag, "_vld"}, 32'(instruction_valid), 32'd1);
        chk({tag, "_dat"}, instruction_i, exp_dat);
        chk({tag, "_err"}, 32'(fetch_error_o), 32'(exp_err));
    endtask

    initial begin
        n_chk       = 0;
        n_err       = 0;
        reset       = 1'b0;
        ins_address = '0;
        prog_we     = 1'b0;
        prog_addr   = '0;
        prog_data   = '0;

        repeat (2) tick();
        prog_wr(32'h0000_0000, 32'h0050_0093);
        prog_wr(32'h0000_0004, 32'h0010_8113);
        prog_wr(32'h0000_0008, 32'h0020_81b3);
        prog_wr(32'h0000_0010, 32'h00a0_0213);
        prog_wr(32'h0000_0040, 32'h0140_0293);

        chk("rst_vld", 32'(instruction_valid), 32'd0);
        chk("rst_dat", instruction_i, NOP);
        chk("rst_err", 32'(fetch_error_o), 32'd0);

        // First fetch straight out of reset
        reset = 1'b1;
        fetch("f0", 32'h0, 32'h0050_0093, 1'b0);

        // Sequential fetch
        fetch("f4", 32'h4, 32'h0010_8113, 1'b0);
        fetch("f8", 32'h8, 32'h0020_81b3, 1'b0);

        // Redirect while waiting on 0x10
        ins_address = 32'h10;
        tick();
        chk("redir_10", 32'(instruction_valid), 32'd0);
        fetch("f40", 32'h40, 32'h0140_0293, 1'b0);

        // Misaligned and out-of-range fetches
        fetch("mis", 32'h6, NOP, 1'b1);
        fetch("oor", DEPTH * 4, NOP, 1'b1);
        fetch("back0", 32'h0, 32'h0050_0093, 1'b0);

        // Program write to the word being served
        prog_wr(32'h0, 32'hDEAD_BEEF);
        chk("hw_drop", 32'(instruction_valid), 32'd0);
        tick();
        chk("hw_early", 32'(instruction_valid), 32'd0);
        tick();
        chk("hw_vld", 32'(instruction_valid), 32'd1);
        chk("hw_dat", instruction_i, 32'hDEAD_BEEF);

        // Write to another word leaves the response alone
        prog_wr(32'h100, 32'h1111_1111);
        chk("nohit_vld", 32'(instruction_valid), 32'd1);
        chk("nohit_dat", instruction_i, 32'hDEAD_BEEF);

        // Out-of-range write is dropped: no restart and no alias onto word 0
        prog_wr(DEPTH * 4, 32'hBAD0_BAD0);
        chk("oorw_vld", 32'(instruction_valid), 32'd1);
        fetch("f4b", 32'h4, 32'h0010_8113, 1'b0);
        fetch("f0b", 32'h0, 32'hDEAD_BEEF, 1'b0);
        fetch("f100", 32'h100, 32'h1111_1111, 1'b0);

        // Reset asserted mid-WAIT
        ins_address = 32'h8;
        tick();
        reset = 1'b0;
        #1;
        chk("rstw_vld", 32'(instruction_valid), 32'd0);
        chk("rstw_dat", instruction_i, NOP);
        chk("rstw_err", 32'(fetch_error_o), 32'd0);
        tick();
        reset = 1'b1;
        fetch("rstw_f8", 32'h8, 32'h0020_81b3, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
